// File: rtl/reg_writeback.sv
// Register-file write side: merges ALU results and load returns onto one write port (A3/WD3/WE3).
// Load data is extended at enqueue and buffered; ALU results always take the write slot first.
module reg_writeback #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_offset,
    input  logic [XLEN-1:0] ld_data,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            WE3,
    output logic            busy
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    // Handshake: a load return transfers on a rising edge where ld_valid && ld_ready;
    // ld_ready depends only on registered state (and rst), never on ld_valid.
    assign full     = (count == CW'(LQ_DEPTH));
    assign empty    = (count == '0);
    assign ld_ready = !rst && !full;
    assign enq      = ld_valid && ld_ready;
    assign deq      = !alu_valid && !empty;
    assign busy     = !empty || WE3;

    assign head_rd   = lq_rd[rd_ptr];
    assign head_data = lq_data[rd_ptr];

    always_comb begin
        ld_byte = ld_data[7:0];
        case (ld_offset)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        // Misaligned halfwords are not trapped here; only the upper/lower lane choice matters.
        ld_half = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = ld_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // An rd=0 entry still consumes its slot but leaves WE3 low and A3/WD3 untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            A3  <= '0;
            WD3 <= '0;
            WE3 <= 1'b0;
        end else if (alu_valid) begin
            WE3 <= (alu_rd != 5'd0);
            if (alu_rd != 5'd0) begin
                A3  <= alu_rd;
                WD3 <= alu_result;
            end
        end else if (deq) begin
            WE3 <= (head_rd != 5'd0);
            if (head_rd != 5'd0) begin
                A3  <= head_rd;
                WD3 <= head_data;
            end
        end else begin
            WE3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus randomized traffic against a queue-based
// reference that tracks pending load returns and the expected write port contents.
module tb_reg_writeback;
    localparam int XLEN     = 32;
    localparam int LQ_DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_offset;
    logic [XLEN-1:0] ld_data;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;
    logic            WE3;
    logic            busy;

    always #5 clk = ~clk;

    reg_writeback #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_funct3(ld_funct3), .ld_offset(ld_offset), .ld_data(ld_data),
        .A3(A3), .WD3(WD3), .WE3(WE3), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pending load returns as {rd, extended data}, oldest first.
    logic [XLEN+4:0] exp_q[$];
    logic            exp_we = 1'b0;
    logic [4:0]      exp_a3 = '0;
    logic [XLEN-1:0] exp_wd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (d >> (int'(off) * 8)) % 256;
                if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (d >> ((int'(off) >= 2) ? 16 : 0)) % 65536;
                if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic drive_idle();
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_result = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_funct3  = '0;
        ld_offset  = '0;
        ld_data    = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        alu_valid  = 1'b1;
        alu_rd     = rd;
        alu_result = res;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                              input logic [31:0] d);
        ld_valid  = 1'b1;
        ld_rd     = rd;
        ld_funct3 = f3;
        ld_offset = off;
        ld_data   = d;
    endtask

    // One clock: check readiness before the edge, advance the reference at the edge,
    // check the write port and busy on the following falling edge.
    task automatic cycle();
        logic            ready_m;
        logic [XLEN+4:0] e;
        #1;
        ready_m = !rst && (exp_q.size() < LQ_DEPTH);
        check("ld_ready", 32'(ld_ready), 32'(ready_m));
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_we = 1'b0;
            exp_a3 = '0;
            exp_wd = '0;
        end else begin
            if (alu_valid) begin
                exp_we = (alu_rd != 0);
                if (alu_rd != 0) begin
                    exp_a3 = alu_rd;
                    exp_wd = alu_result;
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_we = (e[XLEN+4:XLEN] != 0);
                if (e[XLEN+4:XLEN] != 0) begin
                    exp_a3 = e[XLEN+4:XLEN];
                    exp_wd = e[XLEN-1:0];
                end
            end else begin
                exp_we = 1'b0;
            end
            if (ld_valid && ready_m) exp_q.push_back({ld_rd, ref_ext(ld_funct3, ld_offset, ld_data)});
        end
        @(negedge clk);
        check("WE3", 32'(WE3), 32'(exp_we));
        check("A3", 32'(A3), 32'(exp_a3));
        check("WD3", WD3, exp_wd);
        check("busy", 32'(busy), 32'((exp_q.size() != 0) || exp_we));
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a3, input logic [31:0] wd);
        check({tag, "_we"}, 32'(WE3), 32'd1);
        check({tag, "_a3"}, 32'(A3), 32'(a3));
        check({tag, "_wd"}, WD3, wd);
    endtask

    logic [2:0]  ext_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
    logic [1:0]  ext_off [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
    logic [31:0] ext_exp [4] = '{32'hFFFF_FFA0, 32'h0000_00A0, 32'hFFFF_80F4, 32'h80F4_A01C};

    initial begin
        drive_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("idle_we", 32'(WE3), 32'd0);
        check("idle_a3", 32'(A3), 32'd0);
        check("idle_wd", WD3, 32'd0);
        check("idle_ready", 32'(ld_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        drive_alu(5'd5, 32'h6);
        cycle();
        expect_write("alu", 5'd5, 32'h6);
        drive_idle();
        cycle();
        check("alu_after_we", 32'(WE3), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive_load(5'd3, ext_f3[i], ext_off[i], 32'h80F4_A01C);
            cycle();
            drive_idle();
            check("ext_lat1_we", 32'(WE3), 32'd0);
            cycle();
            expect_write("ext", 5'd3, ext_exp[i]);
            cycle();
        end

        drive_load(5'd9, 3'b010, 2'd0, 32'h0000_00F4);
        cycle();
        drive_idle();
        drive_alu(5'd4, 32'h1C);
        cycle();
        expect_write("prio_n2", 5'd4, 32'h1C);
        cycle();
        expect_write("prio_n3", 5'd4, 32'h1C);
        drive_idle();
        cycle();
        expect_write("prio_n4", 5'd9, 32'hF4);
        cycle();

        drive_alu(5'd7, 32'h1234);
        drive_load(5'd10, 3'b010, 2'd0, 32'hAAAA_0001);
        cycle();
        drive_load(5'd11, 3'b010, 2'd0, 32'hBBBB_0002);
        cycle();
        drive_load(5'd12, 3'b010, 2'd0, 32'hCCCC_0003);
        #1;
        check("full_ready", 32'(ld_ready), 32'd0);
        cycle();
        cycle();
        alu_valid = 1'b0;
        cycle();
        expect_write("drain0", 5'd10, 32'hAAAA_0001);
        check("drain_ready", 32'(ld_ready), 32'd1);
        cycle();
        expect_write("drain1", 5'd11, 32'hBBBB_0002);
        drive_idle();
        cycle();
        expect_write("drain2", 5'd12, 32'hCCCC_0003);
        cycle();

        drive_alu(5'd0, 32'hDEAD_BEEF);
        cycle();
        check("x0_alu_we", 32'(WE3), 32'd0);
        drive_idle();
        drive_load(5'd0, 3'b010, 2'd0, 32'h5555_5555);
        cycle();
        drive_idle();
        cycle();
        check("x0_ld_we", 32'(WE3), 32'd0);
        cycle();

        drive_alu(5'd6, 32'h77);
        drive_load(5'd13, 3'b010, 2'd0, 32'h1);
        cycle();
        drive_load(5'd14, 3'b010, 2'd0, 32'h2);
        cycle();
        drive_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("midrst_we", 32'(WE3), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            alu_valid  = ($urandom_range(0, 99) < 45);
            alu_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_result = $urandom;
            ld_valid   = ($urandom_range(0, 99) < 60);
            ld_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_offset  = 2'($urandom_range(0, 3));
            ld_data    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side counterpart of the register file.
- Collects completed results from the ALU path and the load-return path and extends load data by access type.
- Arbitrates between the two sources and drives the register file write port (A3/WD3/WE3) one entry per cycle.
- Load returns are buffered in a small FIFO so they never collide with ALU writebacks.

Parameters:
- XLEN, 32, datapath width.
- LQ_DEPTH, 2, load-return FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  input  5  ALU destination register.
- alu_result  input  XLEN  ALU result.
- ld_valid  input  1  load return offered.
- ld_ready  output  1  load return accepted when ld_valid&&ld_ready at the clock edge.
- ld_rd  input  5  load destination register.
- ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_offset  input  2  byte address bits [1:0] of the load.
- ld_data  input  XLEN  raw aligned memory word.
- A3  output  5  register file write address.
- WD3  output  XLEN  register file write data.
- WE3  output  1  register file write enable.
- busy  output  1  FIFO non-empty or write in flight.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO pointers and count cleared.
  - A3=0, WD3=0, WE3=0 from the following cycle.
  - ld_ready=0 while rst is high.
  - Any in-flight entry is discarded; no write is issued.
- Output stage:
  - A3/WD3/WE3 are registered.
  - WE3 is high for exactly one cycle per written entry.
  - WE3 is low otherwise; A3/WD3 hold their last value while WE3 is low.
- ALU path:
  - alu_valid at edge N produces WE3=1, A3=alu_rd, WD3=alu_result in cycle N+1.
  - Latency is 1 cycle.
- Load path:
  - Accepted returns are enqueued with the already-extended data.
  - Extension is computed combinationally at enqueue.
  - FIFO head dequeues at edge M only if alu_valid=0 at edge M. Output is visible in cycle M+1.
  - No same-cycle bypass: minimum latency from accept to WE3 is 2 cycles.
  - ALU always has priority; a continuous alu_valid stream starves loads by design. The upstream pipeline guarantees bubbles.
- ld_ready = !full, a registered-count comparison.
  - Enqueue when full is never possible.
  - Simultaneous enqueue and dequeue when count=LQ_DEPTH-1 is legal; count is unchanged.
- Extension, with b = byte at lane ld_offset and h = halfword at lane ld_offset[1]:
  - LB: sign-extend b.
  - LBU: zero-extend b.
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: full word; ld_offset ignored.
  - Other funct3 values: treated as LW.
  - Misaligned halfword (ld_offset[0]=1): uses lane ld_offset[1]; no trap is raised here.
- x0 rule:
  - Any entry with rd=0 (ALU or load) still occupies its writeback slot and is consumed from the FIFO.
  - WE3 is forced 0 for that slot.
- busy = (count!=0) || WE3.
- Pointers wrap modulo LQ_DEPTH.
- Count is XLEN-independent, width clog2(LQ_DEPTH)+1.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: WE3=0, A3=0, WD3=0, ld_ready=1, busy=0 in the cycle after release.
- Single ALU result:
  - Stimulus: alu_valid=1, alu_rd=5, alu_result=0x00000006 at edge N.
  - Required: cycle N+1 has WE3=1, A3=5, WD3=0x00000006; cycle N+2 has WE3=0.
- Load extension (each is a single load with no ALU traffic; all show WE3 two cycles after accept):
  - LB: ld_data=0x80F4A01C, offset=1 -> WD3=0xFFFFFFA0.
  - LBU: same data and offset -> WD3=0x000000A0.
  - LH: same data, offset=2 -> WD3=0xFFFF80F4.
  - LW: same data -> WD3=0x80F4A01C.
- Collision and priority:
  - Stimulus: load rd=9 data 0x000000F4 (LW) accepted at N; alu_valid rd=4 result 0x1C at N+1 and N+2.
  - Required: WE3 writes A3=4 in cycles N+2 and N+3, then A3=9 WD3=0xF4 in cycle N+4.
- FIFO full:
  - Stimulus: alu_valid held 1, three back-to-back loads offered.
  - Required: first two accepted; ld_ready=0 with third load stalled.
  - After alu_valid drops: entries written in order, ld_ready returns 1, third load then accepted.
- x0 and reset mid-operation:
  - x0: ALU rd=0 result 0xDEADBEEF -> WE3 stays 0.
  - Reset mid-operation: FIFO holding 2 loads, rst pulsed 1 cycle -> no subsequent WE3, busy=0, count=0.
